// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (common with the slave bank),
// default bus widths and the response error code.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_LENGTH = 8;
  localparam int APB_DATA_LENGTH = 32;

  // Value driven on rsp_err when a transfer is aborted by the wait-state timer.
  localparam logic RSP_ERR_TIMEOUT = 1'b1;
  localparam logic RSP_ERR_OK      = 1'b0;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer: counts pready-low ACCESS cycles, flags the last allowed one.
// Latency: count updates on the clock edge after clr/inc; expired is combinational on the count.
// Backpressure: none; saturates instead of wrapping. TIMEOUT=0 never expires.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic prst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit ENABLED = (TIMEOUT != 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = ENABLED && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester with a one-entry response register and wait-state abort.
// Latency: psel from accept edge E0, penable from E1, response from E2 plus one edge per wait state.
// Backpressure: cmd_ready only in IDLE with an empty response slot; rsp_valid held until rsp_ready.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_LENGTH = APB_ADDR_LENGTH,
  parameter int DATA_LENGTH = APB_DATA_LENGTH,
  parameter int TIMEOUT     = 16
) (
  input  logic                   pclk,
  input  logic                   prst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_LENGTH-1:0] cmd_addr,
  input  logic [DATA_LENGTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_LENGTH-1:0] paddr,
  output logic [DATA_LENGTH-1:0] pwdata,
  input  logic                   pready,
  input  logic [DATA_LENGTH-1:0] prdata
);

  apb_state_e             state, state_nxt;
  logic                   psel_nxt, penable_nxt;
  logic                   rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_LENGTH-1:0] rsp_rdata_nxt;
  logic                   cmd_fire;
  logic                   tmr_clr, tmr_inc, tmr_expired;

  // The response slot blocks acceptance even in the cycle it is being drained.
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk    (pclk),
    .prst_n  (prst_n),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel;
    penable_nxt   = penable;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    tmr_clr       = 1'b0;
    tmr_inc       = 1'b0;

    if (rsp_valid && rsp_ready) begin
      rsp_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        tmr_clr     = 1'b1;
      end
      ACCESS: begin
        // Completion takes priority over an abort on the same edge.
        if (pready) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = RSP_ERR_OK;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
        end else if (tmr_expired) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = RSP_ERR_TIMEOUT;
          rsp_rdata_nxt = '0;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  // Address/data only load on accept, so they stay frozen while psel is high.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (cmd_fire) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master (TIMEOUT=4): scenario tasks drive stimulus and check APB timing,
// a negedge scoreboard process checks every response against queued expectations.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          prst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  logic rsp_seen;

  apb_master #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // Scoreboard: each new response is compared once, on the first negedge it is visible.
  always @(negedge pclk) begin
    exp_t e;
    if (!prst_n) begin
      rsp_seen = 1'b0;
    end else if (rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin
          n_err++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   rsp_err, rsp_rdata, e.err, e.rdata);
        end
      end
    end else if (!rsp_valid) begin
      rsp_seen = 1'b0;
    end
  end

  // Drive one command at the current negedge; returns at the negedge after accept edge E0.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    prst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    n_vec++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got psel/pen/pwr/rv/re=%b, required 00000",
               {psel, penable, pwrite, rsp_valid, rsp_err});
    end
    n_vec++;
    if ({paddr, pwdata, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, required all 0", paddr, pwdata, rsp_rdata);
    end
    prst_n = 1'b1;
    @(negedge pclk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
  endtask

  // Transfer whose slave holds pready low for nwait ACCESS cycles, then completes.
  task automatic test_transfer(input string name, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int nwait);
    exp_t e;
    pready = 1'b0;
    prdata = 32'h0BAD_F00D;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got cmd_ready=%b, required 1", name, cmd_ready);
    end
    e.err = 1'b0;
    e.rdata = wr ? '0 : rd;
    exp_q.push_back(e);
    send(wr, a, wd);
    n_vec++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, wr, a, wd}) begin
      n_err++;
      $display("FAIL %s_E0: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, required 1 0 %b %h %h",
               name, psel, penable, pwrite, paddr, pwdata, wr, a, wd);
    end
    for (int k = 1; k <= nwait + 2; k++) begin
      if (k == nwait + 2) begin
        pready = 1'b1;
        prdata = rd;
      end
      @(negedge pclk);
      n_vec++;
      if (k < nwait + 2) begin
        if ({psel, penable, rsp_valid, pwrite, paddr, pwdata} !== {3'b110, wr, a, wd}) begin
          n_err++;
          $display("FAIL %s_E%0d: got psel/pen/rv=%b%b%b paddr=%h pwdata=%h, required 110 %h %h",
                   name, k, psel, penable, rsp_valid, paddr, pwdata, a, wd);
        end
      end else if ({psel, penable, rsp_valid} !== 3'b001) begin
        n_err++;
        $display("FAIL %s_E%0d: got psel/pen/rv=%b%b%b, required 001", name, k, psel, penable, rsp_valid);
      end
    end
    pready = 1'b0;
    prdata = 32'h0BAD_F00D;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got rsp_valid=%b, required 0", name, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    e.err = 1'b1;
    e.rdata = '0;
    exp_q.push_back(e);
    send(1'b0, 8'h5A, 32'h0);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge pclk);
      n_vec++;
      if (k <= TO) begin
        if ({psel, penable, rsp_valid} !== 3'b110) begin
          n_err++;
          $display("FAIL timeout_E%0d: got psel/pen/rv=%b%b%b, required 110", k, psel, penable, rsp_valid);
        end
      end else if ({psel, penable, rsp_valid} !== 3'b001) begin
        n_err++;
        $display("FAIL timeout_abort: got psel/pen/rv=%b%b%b, required 001", psel, penable, rsp_valid);
      end
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    pready = 1'b1;
    prdata = 32'h1111_2222;
    e.err = 1'b0;
    e.rdata = '0;
    exp_q.push_back(e);
    send(1'b1, 8'h20, 32'hA5A5_0001);
    @(negedge pclk);
    @(negedge pclk);
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_rsp: got rsp_valid=%b, required 1", rsp_valid);
    end
    e.err = 1'b0;
    e.rdata = 32'h1111_2222;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      n_vec++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b001) begin
        n_err++;
        $display("FAIL b2b_hold%0d: got cmd_ready/psel/rv=%b%b%b, required 001", i, cmd_ready, psel, rsp_valid);
      end
    end
    rsp_ready = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain_cycle: got cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge pclk);
    rsp_ready = 1'b0;
    n_vec++;
    if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_after_hs: got cmd_ready/psel/rv=%b%b%b, required 100", cmd_ready, psel, rsp_valid);
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    n_vec++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 8'h21}) begin
      n_err++;
      $display("FAIL b2b_accept: got psel/pen/pwr=%b%b%b paddr=%h, required 100 21",
               psel, penable, pwrite, paddr);
    end
    repeat (2) @(negedge pclk);
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_rsp: got rsp_valid=%b, required 1", rsp_valid);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    send(1'b1, 8'h77, 32'hCAFE_F00D);
    @(negedge pclk);
    @(negedge pclk);
    #2 prst_n = 1'b0;
    #1;
    n_vec++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_ctrl: got psel/pen/pwr/rv/re=%b, required 00000",
               {psel, penable, pwrite, rsp_valid, rsp_err});
    end
    n_vec++;
    if ({paddr, pwdata, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL midrst_data: got paddr=%h pwdata=%h rdata=%h, required all 0", paddr, pwdata, rsp_rdata);
    end
    @(negedge pclk);
    prst_n = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      n_vec++;
      if ({psel, rsp_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL midrst_quiet%0d: got psel=%b rsp_valid=%b, required 0 0", i, psel, rsp_valid);
      end
    end
    pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_transfer("wr0", 1'b1, 8'h12, 32'hDEAD_BEEF, 32'h0, 0);
    test_transfer("rd3", 1'b0, 8'h12, 32'h0000_0042, 32'hDEAD_BEEF, 3);
    test_transfer("wr3", 1'b1, 8'hC3, 32'h1234_5678, 32'h0, 3);
    test_transfer("rd1", 1'b0, 8'hFF, 32'h0, 32'h8000_0001, 1);
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rsp_missing: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that sits directly upstream of the APB slave bank. It accepts read/write commands from a host-side valid/ready port and drives the APB setup/access sequence (psel, penable, paddr, pwrite, pwdata). It returns read data, or a timeout error, through a one-entry response register. A wait-state timer aborts transfers whose slave never raises pready.

## Interface
- ADDR_LENGTH, 8: APB address width.
- DATA_LENGTH, 32: APB data width.
- TIMEOUT, 16: maximum ACCESS cycles with pready low before abort; 0 disables the timeout.
- pclk  input  1  APB clock; all state on rising edge.
- prst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_LENGTH  transfer address.
- cmd_wdata  input  DATA_LENGTH  write data.
- rsp_valid  output  1  response held until rsp_ready.
- rsp_ready  input  1  host consumes response.
- rsp_rdata  output  DATA_LENGTH  read data; 0 for writes and timeouts.
- rsp_err  output  1  1 = transfer aborted by timeout.
- psel, penable, pwrite  output  1  APB controls.
- paddr  output  ADDR_LENGTH  APB address.
- pwdata  output  DATA_LENGTH  APB write data.
- pready  input  1  slave completion.
- prdata  input  DATA_LENGTH  slave read data.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0. cmd_ready = (state==IDLE) && !rsp_valid. This is combinational, with no dependence on cmd_valid.
- On accept: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, then go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS and clear the wait counter.
- ACCESS: psel=1, penable=1.
  - pready=1: go to IDLE, psel/penable go to 0, rsp_valid goes to 1, and rsp_err=0. rsp_rdata = prdata for a read, 0 for a write.
  - pready=0 and TIMEOUT≠0 and wait count == TIMEOUT-1: go to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Otherwise, increment the wait counter and stay in ACCESS.
- paddr, pwrite and pwdata hold their last values in IDLE. They do not change while psel=1.
- Response slot: rsp_valid clears on rsp_valid && rsp_ready. No new command is accepted while rsp_valid=1, including the cycle in which rsp_ready is high, so the minimum gap between responses is fixed.
- Wait counter width is $clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.

## Timing
- Reset (async assert, sync-released domain) sets: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
- Reset assertion mid-transfer drops psel/penable immediately, without waiting for pclk. The in-flight command is discarded and no response is produced.
- All APB outputs and response outputs are registered.
- Latency, with accept at edge E0:
  - psel=1 from E0.
  - penable=1 from E1.
  - If pready=1 in the first ACCESS cycle, rsp_valid=1 from E2. Minimum is 2 edges from accept to response.
- Each pready-low ACCESS cycle adds one edge.
- Timeout aborts at edge E1+TIMEOUT.
- pready=1 in the same cycle the timeout would fire: completion wins, rsp_err=0.
- pready is ignored outside ACCESS.
- prdata is sampled only at the completing edge.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), shared with the slave;
  - default ADDR_LENGTH/DATA_LENGTH constants;
  - a response-error code constant.
- One natural sub-module: apb_wait_timer, the clear/increment/saturating counter with an expired output, parameterised by TIMEOUT.
- The FSM and response register stay in apb_master.

## Test plan
- Write 0x12 with data 0xDEADBEEF, slave pready=1 in the first ACCESS cycle -> psel at E0, penable at E1, rsp_valid at E2, rsp_err=0, rsp_rdata=0.
- Read 0x12 with pready delayed 3 cycles and prdata=0xDEADBEEF -> rsp_valid at E5, rsp_rdata=0xDEADBEEF, paddr stable throughout.
- TIMEOUT=4, pready held low -> abort at E5, psel=0 after E5, rsp_err=1, rsp_rdata=0.
- TIMEOUT=4, pready rises in the 4th ACCESS cycle -> normal completion, rsp_err=0.
- rsp_ready held low for 5 cycles with cmd_valid high -> cmd_ready=0 throughout. Next command accepted the edge after the response handshake.
- prst_n pulsed low during ACCESS -> psel/penable go to 0 immediately, every output at its reset value, no rsp_valid after release.
